// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the datapath and pipeline_hazard_controller.
// master = datapath side (drives hazard inputs, consumes stall/flush/forward);
// slave  = the controller itself.
// HAZARD_PERF_CNT_EN adds the StallCycles/FlushCount performance outputs.
interface pipeline_hazard_controller_if;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E;
  logic [4:0] RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW;
  logic       PCSrcE;
  logic       MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MemError;
  logic [1:0] state_dbg;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input  StallCycles, FlushCount,
`endif
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    output RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemError, state_dbg
  );

  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output StallCycles, FlushCount,
`endif
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
    input  RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemError, state_dbg
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for a 5-stage F/D/E/M/W pipeline.
// Forwarding, load-use stall and branch flush are combinational; data-memory
// waits are sequenced by a RUN/MEM_WAIT/ERR FSM with a bounded-wait timeout.
// state_dbg encoding: 0 = RUN, 1 = MEM_WAIT, 2 = ERR.
// Optional macro HAZARD_PERF_CNT_EN adds StallCycles/FlushCount counters.
//
// Memory handshake: MemReqM is the request (valid) from the Memory stage and
// MemReadyM the completion (ready) from data memory; the access completes in
// the cycle where both are high. A request without ready freezes the pipe in
// that same cycle, and the freeze lifts in the cycle where ready arrives.
module pipeline_hazard_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_hazard_controller_if.slave   hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] wait_inc;

  logic lw_stall, mem_stall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic mem_error;
  logic [1:0] fwd_a, fwd_b, fwd_a_raw, fwd_b_raw;

  // Memory stage has priority over writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == rs)) return 2'b10;
    if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a_raw = fwd_sel(hz.Rs1E);
  assign fwd_b_raw = fwd_sel(hz.Rs2E);
  assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign mem_stall = hz.MemReqM && !hz.MemReadyM;
  // Saturating increment so the counter can never wrap back to a small value.
  assign wait_inc  = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state: a wait is entered on the first stalled cycle (count 1) and
  // left as soon as the Memory stage no longer stalls.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc >= TIMEOUT_VAL) state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stage controls. Reset overrides everything so no stale state leaks out
  // while rst is high; a memory freeze masks load-use and branch handling,
  // which re-evaluate once the freeze lifts.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_w   = 1'b0;
    mem_error = 1'b0;
    fwd_a     = fwd_a_raw;
    fwd_b     = fwd_b_raw;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
      fwd_a   = 2'b00;
      fwd_b   = 2'b00;
    end else if (state_q == ST_ERR) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      stall_m   = 1'b1;
      flush_w   = 1'b1;
      mem_error = 1'b1;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = lw_stall;
      stall_d = lw_stall;
      flush_d = hz.PCSrcE;
      flush_e = lw_stall || hz.PCSrcE;
    end
  end

  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushW    = flush_w;
  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.MemError  = mem_error;
  assign hz.state_dbg = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Count stalled-fetch and execute-flush cycles; frozen once in ERR.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (state_q != ST_ERR) begin
      if (stall_f) stall_cycles_d = stall_cycles_q + 32'd1;
      if (flush_e) flush_count_d  = flush_count_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hz.StallCycles = stall_cycles_q;
  assign hz.FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller (built with TIMEOUT_CYCLES=4).
// Output vector order: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,
//                       ForwardAE,ForwardBE,MemError}.
module tb_pipeline_hazard_controller;

  localparam int TO = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsrce;
    logic       rwm, rww, pcsrc, memreq, memrdy;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [11:0] exp;
    string       name;
  } tv_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if hz();

  pipeline_hazard_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  tv_t tbl[$];

  // Reference model: consecutive stalled-memory cycles and a sticky error.
  int          m_cnt = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_sc  = '0;
  logic [31:0] m_fc  = '0;

  function automatic logic [1:0] ref_fwd(vec_t v, logic [4:0] rs);
    if (v.rwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
    if (v.rww && v.rdw != 0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_lw(vec_t v);
    return (v.rsrce == 2'b01) && (v.rde != 0) && (v.rde == v.rs1d || v.rde == v.rs2d);
  endfunction

  function automatic logic [11:0] model_out(vec_t v);
    logic [1:0] fa, fb;
    bit lw, ms;
    fa = ref_fwd(v, v.rs1e);
    fb = ref_fwd(v, v.rs2e);
    lw = ref_lw(v);
    ms = v.memreq && !v.memrdy;
    if (v.rst) return 12'b0000_111_00_00_0;
    if (m_err) return {4'b1111, 3'b001, fa, fb, 1'b1};
    if (ms)    return {4'b1111, 3'b001, fa, fb, 1'b0};
    return {lw, lw, 2'b00, v.pcsrc, lw | v.pcsrc, 1'b0, fa, fb, 1'b0};
  endfunction

  function automatic int model_state();
    if (m_err) return 2;
    if (m_cnt != 0) return 1;
    return 0;
  endfunction

  task automatic model_step(vec_t v);
    logic [11:0] e;
    e = model_out(v);
    if (v.rst) begin
      m_cnt = 0; m_err = 1'b0; m_sc = '0; m_fc = '0;
    end else if (!m_err) begin
      if (e[11]) m_sc = m_sc + 32'd1;
      if (e[6])  m_fc = m_fc + 32'd1;
      if (v.memreq && !v.memrdy) begin
        m_cnt++;
        if (m_cnt >= TO) m_err = 1'b1;
      end else begin
        m_cnt = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(vec_t v);
    rst           = v.rst;
    hz.Rs1D       = v.rs1d;
    hz.Rs2D       = v.rs2d;
    hz.Rs1E       = v.rs1e;
    hz.Rs2E       = v.rs2e;
    hz.RdE        = v.rde;
    hz.RdM        = v.rdm;
    hz.RdW        = v.rdw;
    hz.ResultSrcE = v.rsrce;
    hz.RegWriteM  = v.rwm;
    hz.RegWriteW  = v.rww;
    hz.PCSrcE     = v.pcsrc;
    hz.MemReqM    = v.memreq;
    hz.MemReadyM  = v.memrdy;
  endtask

  function automatic logic [11:0] dut_out();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE,
            hz.FlushW, hz.ForwardAE, hz.ForwardBE, hz.MemError};
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive after the falling edge, compare 1ns later, advance model.
  // exp_state < 0 skips the FSM state comparison.
  task automatic step(vec_t v, bit use_exp, logic [11:0] exp, string name, int exp_state);
    @(negedge clk);
    drive(v);
    #1;
    if (use_exp) exp_q.push_back(exp);
    else         exp_q.push_back(model_out(v));
    cmp(name, 32'(dut_out()), 32'(exp_q.pop_front()));
    if (exp_state >= 0) cmp({name, "_state"}, 32'(hz.state_dbg), 32'(exp_state));
`ifdef HAZARD_PERF_CNT_EN
    cmp({name, "_stallcyc"}, hz.StallCycles, m_sc);
    cmp({name, "_flushcnt"}, hz.FlushCount, m_fc);
`endif
    model_step(v);
  endtask

  task automatic add(vec_t v, logic [11:0] exp, string name);
    tv_t t;
    t.v = v; t.exp = exp; t.name = name;
    tbl.push_back(t);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t v, idle, rstv, ms;
    idle = '0;
    rstv = '0; rstv.rst = 1'b1;
    ms   = '0; ms.memreq = 1'b1;

    // Initial reset (state unknown before it, so not compared).
    @(negedge clk); drive(rstv);
    @(negedge clk); drive(rstv);
    model_step(rstv);

    // Combinational vectors, all from RUN.
    add(rstv, 12'b0000_111_00_00_0, "reset_out");
    v = '0; v.rdm = 5; v.rwm = 1; v.rdw = 5; v.rww = 1; v.rs1e = 5;
    add(v, 12'b0000_000_10_00_0, "fwdA_M_prio");
    v.rdm = 0;
    add(v, 12'b0000_000_01_00_0, "fwdA_W");
    v.rdw = 0;
    add(v, 12'b0000_000_00_00_0, "fwdA_x0");
    v = '0; v.rs2e = 9; v.rdw = 9; v.rww = 1;
    add(v, 12'b0000_000_00_01_0, "fwdB_W");
    v = '0; v.rs1e = 3; v.rs2e = 3; v.rdm = 3; v.rwm = 1; v.rdw = 3; v.rww = 1;
    add(v, 12'b0000_000_10_10_0, "fwdAB_M");
    v = '0; v.rs1e = 4; v.rdm = 4; v.rwm = 0; v.rdw = 4; v.rww = 1;
    add(v, 12'b0000_000_01_00_0, "fwdA_noRegWriteM");
    v = '0; v.rsrce = 2'b01; v.rde = 7; v.rs2d = 7;
    add(v, 12'b1100_010_00_00_0, "lw_stall");
    add(idle, 12'b0000_000_00_00_0, "lw_next_clear");
    v = '0; v.rsrce = 2'b01; v.rde = 0; v.rs1d = 0;
    add(v, 12'b0000_000_00_00_0, "lw_x0");
    v = '0; v.rsrce = 2'b10; v.rde = 7; v.rs1d = 7;
    add(v, 12'b0000_000_00_00_0, "not_load");
    v = '0; v.pcsrc = 1;
    add(v, 12'b0000_110_00_00_0, "branch_flush");

    foreach (tbl[i]) step(tbl[i].v, 1'b1, tbl[i].exp, tbl[i].name, -1);

    // Memory wait of 3 cycles then ready (one short of timeout); a load-use
    // hazard during the freeze must be masked.
    step(ms, 1'b1, 12'b1111_001_00_00_0, "mw_c0", 0);
    v = ms; v.rsrce = 2'b01; v.rde = 6; v.rs1d = 6;
    step(v,  1'b1, 12'b1111_001_00_00_0, "mw_c1_lw_masked", 1);
    step(ms, 1'b1, 12'b1111_001_00_00_0, "mw_c2", 1);
    v = ms; v.memrdy = 1'b1;
    step(v,  1'b1, 12'b0000_000_00_00_0, "mw_release", 1);
    step(idle, 1'b1, 12'b0000_000_00_00_0, "mw_back_run", 0);

    // Timeout: 4 stalled cycles, then ERR sticky even once ready arrives.
    for (int i = 0; i < TO; i++)
      step(ms, 1'b1, 12'b1111_001_00_00_0, "to_wait", -1);
    step(ms, 1'b1, 12'b1111_001_00_00_1, "to_err", 2);
    v = ms; v.memrdy = 1'b1;
    step(v, 1'b1, 12'b1111_001_00_00_1, "to_err_hold", 2);
    step(idle, 1'b1, 12'b1111_001_00_00_1, "to_err_hold2", 2);
    step(rstv, 1'b1, 12'b0000_111_00_00_0, "to_rst", 2);
    step(idle, 1'b1, 12'b0000_000_00_00_0, "to_after_rst", 0);

    // Reset in the middle of a wait.
    step(ms, 1'b1, 12'b1111_001_00_00_0, "rmw_c0", 0);
    step(ms, 1'b1, 12'b1111_001_00_00_0, "rmw_c1", 1);
    step(rstv, 1'b1, 12'b0000_111_00_00_0, "rmw_rst", 1);
    step(idle, 1'b1, 12'b0000_000_00_00_0, "rmw_after", 0);

    // Randomised run against the reference model.
    for (int n = 0; n < 1500; n++) begin
      v        = '0;
      v.rst    = ($urandom_range(0, 49) == 0);
      v.rs1d   = 5'($urandom_range(0, 3));
      v.rs2d   = 5'($urandom_range(0, 3));
      v.rs1e   = 5'($urandom_range(0, 3));
      v.rs2e   = 5'($urandom_range(0, 3));
      v.rde    = 5'($urandom_range(0, 3));
      v.rdm    = 5'($urandom_range(0, 3));
      v.rdw    = 5'($urandom_range(0, 3));
      v.rsrce  = 2'($urandom_range(0, 3));
      v.rwm    = 1'($urandom_range(0, 1));
      v.rww    = 1'($urandom_range(0, 1));
      v.pcsrc  = ($urandom_range(0, 3) == 0);
      v.memreq = ($urandom_range(0, 2) == 0);
      v.memrdy = 1'($urandom_range(0, 1));
      if (ref_lw(v)) v.pcsrc = 1'b0;
      assert (!(ref_lw(v) && v.pcsrc)) else $error("lw/branch overlap in stimulus");
      step(v, 1'b0, 12'h000, "rand", model_state());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
